// File: rtl/fe_sample_reorder_buffer.sv
// Per-board transposer: collects 16 FE packets (128 ch each) into a ping-pong bank of
// channel-major 256-bit words. Optional macro DROP_CNT_EN adds a saturating drop counter.

module fe_srb_lane #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

module fe_sample_reorder_buffer #(
  parameter int CHANNELS         = 128,
  parameter int SAMPLES_PER_WORD = 16,
  parameter int SAMPLE_W         = 16,
  parameter int CH_AW            = 7,
  parameter int SLOT_AW          = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rx_valid,
  input  logic                                 rx_sop,
  input  logic [SAMPLE_W-1:0]                  rx_data,
  input  logic [15:0]                          rx_time_stamp,
  input  logic                                 BRAM_rd_request,
  output logic                                 BRAM_ready_mask,
  output logic [SAMPLES_PER_WORD*SAMPLE_W-1:0] BRAM_rd_data,
  output logic [15:0]                          bank_time_stamp,
  output logic                                 overflow,
  output logic                                 pkt_err
`ifdef DROP_CNT_EN
  ,
  output logic [15:0]                          drop_count
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_DROP = 2'd2;
  localparam logic [1:0] B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2;
  localparam logic [CH_AW-1:0]   CH_LAST   = CH_AW'(CHANNELS-1);
  localparam logic [SLOT_AW-1:0] SLOT_LAST = SLOT_AW'(SAMPLES_PER_WORD-1);

  logic [1:0]         st;
  logic [1:0]         bank_st [2];
  logic [15:0]        bank_ts [2];
  logic               wb, rb;
  logic [CH_AW-1:0]   ch_cnt, rd_addr, wr_ch;
  logic [SLOT_AW-1:0] slot_cnt;
  logic               rel_hold;

  logic sop_v, wb_full, start_ok, drop_now, beat, wr_en, rd_accept, release_now;

  assign sop_v       = rx_valid & rx_sop;
  assign wb_full     = (bank_st[wb] == B_FULL);
  assign start_ok    = sop_v & ((st == S_FILL) | !wb_full);
  assign drop_now    = sop_v & (st != S_FILL) & wb_full;
  assign beat        = (st == S_FILL) & rx_valid & !rx_sop;
  assign wr_en       = start_ok | beat;
  assign wr_ch       = rx_sop ? '0 : ch_cnt;
  assign rd_accept   = BRAM_rd_request & BRAM_ready_mask;
  assign release_now = rd_accept & (rd_addr == CH_LAST);

  // Bank under drain is FULL, so the writer can never touch it.
  assign bank_time_stamp = bank_ts[rb];

  for (genvar l = 0; l < SAMPLES_PER_WORD; l++) begin : g_lane
    fe_srb_lane #(.AW(CH_AW+1), .DW(SAMPLE_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en & (slot_cnt == SLOT_AW'(l))),
      .waddr ({wb, wr_ch}),
      .wdata (rx_data),
      .re    (rd_accept),
      .raddr ({rb, rd_addr}),
      .rdata (BRAM_rd_data[l*SAMPLE_W +: SAMPLE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= S_IDLE;
      bank_st[0]      <= B_EMPTY;
      bank_st[1]      <= B_EMPTY;
      bank_ts[0]      <= '0;
      bank_ts[1]      <= '0;
      wb              <= 1'b0;
      rb              <= 1'b0;
      ch_cnt          <= '0;
      slot_cnt        <= '0;
      rd_addr         <= '0;
      rel_hold        <= 1'b0;
      BRAM_ready_mask <= 1'b0;
      overflow        <= 1'b0;
      pkt_err         <= 1'b0;
`ifdef DROP_CNT_EN
      drop_count      <= '0;
`endif
    end else begin
      overflow <= 1'b0;
      pkt_err  <= 1'b0;

      if (drop_now) begin
        overflow <= 1'b1;
        st       <= S_DROP;
`ifdef DROP_CNT_EN
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
      end else if (start_ok) begin
        // An early sop abandons the partial slot and restarts it with this packet.
        if (st == S_FILL) pkt_err <= 1'b1;
        ch_cnt      <= CH_AW'(1);
        st          <= S_FILL;
        bank_st[wb] <= B_FILLING;
        if (slot_cnt == '0) bank_ts[wb] <= rx_time_stamp;
      end else if (beat) begin
        if (ch_cnt == CH_LAST) begin
          ch_cnt <= '0;
          st     <= S_IDLE;
          if (slot_cnt == SLOT_LAST) begin
            bank_st[wb] <= B_FULL;
            wb          <= ~wb;
            slot_cnt    <= '0;
          end else begin
            slot_cnt <= slot_cnt + SLOT_AW'(1);
          end
        end else begin
          ch_cnt <= ch_cnt + CH_AW'(1);
        end
      end

      if (rd_accept) begin
        rd_addr <= rd_addr + CH_AW'(1);
        if (release_now) begin
          bank_st[rb] <= B_EMPTY;
          rb          <= ~rb;
        end
      end

      // Ready drops for at least two cycles after a release so the arbiter sees the edge.
      rel_hold        <= release_now;
      BRAM_ready_mask <= !release_now & !rel_hold & (bank_st[rb] == B_FULL);
    end
  end
endmodule

// File: tb/tb_fe_sample_reorder_buffer.sv
// Randomized self-checking bench for fe_sample_reorder_buffer with a packet-level
// transpose model (queues of expected bank words and time stamps).

module tb_fe_sample_reorder_buffer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_valid, rx_sop, BRAM_rd_request;
  logic [15:0]  rx_data, rx_time_stamp;
  logic         BRAM_ready_mask, overflow, pkt_err;
  logic [255:0] BRAM_rd_data;
  logic [15:0]  bank_time_stamp;
`ifdef DROP_CNT_EN
  logic [15:0]  drop_count;
`endif

  fe_sample_reorder_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_valid        (rx_valid),
    .rx_sop          (rx_sop),
    .rx_data         (rx_data),
    .rx_time_stamp   (rx_time_stamp),
    .BRAM_rd_request (BRAM_rd_request),
    .BRAM_ready_mask (BRAM_ready_mask),
    .BRAM_rd_data    (BRAM_rd_data),
    .bank_time_stamp (bank_time_stamp),
    .overflow        (overflow),
    .pkt_err         (pkt_err)
`ifdef DROP_CNT_EN
    ,
    .drop_count      (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: samples of the bank being filled, plus queues of completed banks.
  logic [15:0]  cur [128][16];
  logic [255:0] fullq [$];
  logic [15:0]  tsq [$];
  logic [15:0]  cur_ts;
  int           cur_slot, full_banks;
  bit           err_pending;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic model_reset;
    fullq.delete(); tsq.delete();
    cur_slot = 0; full_banks = 0; err_pending = 0; cur_ts = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; rx_valid = 0; rx_sop = 0; rx_data = '0; rx_time_stamp = '0; BRAM_rd_request = 0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    model_reset;
  endtask

  // Sends one packet (nbeats < 128 leaves it truncated) and checks the pulses it causes.
  task automatic send_pkt(input logic [15:0] ts, input bit pat, input int nbeats, input bit gaps);
    logic [15:0]  s [128];
    logic [255:0] w;
    bit drop, exp_err;
    int ov, pe;
    drop = (full_banks == 2);
    exp_err = err_pending;
    for (int ch = 0; ch < 128; ch++) s[ch] = pat ? 16'((ch << 8) | cur_slot) : 16'($urandom);
    ov = 0; pe = 0;
    for (int ch = 0; ch < nbeats; ch++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        rx_valid = 0; rx_sop = 0;
        tick; ov += int'(overflow); pe += int'(pkt_err);
      end
      rx_valid = 1; rx_sop = (ch == 0); rx_data = s[ch]; rx_time_stamp = ts;
      tick; ov += int'(overflow); pe += int'(pkt_err);
    end
    rx_valid = 0; rx_sop = 0;
    checks++;
    if (ov !== (drop ? 1 : 0)) begin
      errors++; $display("FAIL overflow_pulses ts=%h: got %0d exp %0d", ts, ov, drop ? 1 : 0);
    end
    checks++;
    if (pe !== (exp_err ? 1 : 0)) begin
      errors++; $display("FAIL pkt_err_pulses ts=%h: got %0d exp %0d", ts, pe, exp_err ? 1 : 0);
    end
    if (nbeats < 128) err_pending = !drop;
    else begin
      err_pending = 0;
      if (!drop) begin
        for (int ch = 0; ch < 128; ch++) cur[ch][cur_slot] = s[ch];
        if (cur_slot == 0) cur_ts = ts;
        cur_slot++;
        if (cur_slot == 16) begin
          for (int c = 0; c < 128; c++) begin
            for (int t = 0; t < 16; t++) w[t*16 +: 16] = cur[c][t];
            fullq.push_back(w);
          end
          tsq.push_back(cur_ts);
          full_banks++;
          cur_slot = 0;
        end
      end
    end
  endtask

  task automatic send_n(input int n, input logic [15:0] ts0, input bit pat, input bit gaps);
    for (int i = 0; i < n; i++) send_pkt(ts0 + 16'(i), pat, 128, gaps);
  endtask

  // Drains one bank with back-to-back requests, then probes the release hold window.
  task automatic drain_bank(input bit chk5);
    logic [255:0] exp_w, last_w;
    int n;
    n = 0;
    while (!BRAM_ready_mask && n < 6) begin tick; n++; end
    checks++;
    if (!BRAM_ready_mask || fullq.size() < 128) begin
      errors++; $display("FAIL ready_wait: ready=%b model_words=%0d", BRAM_ready_mask, fullq.size());
      return;
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (BRAM_ready_mask !== 1'b1 || bank_time_stamp !== tsq[0]) begin
        errors++; $display("FAIL drain_ready_ts i=%0d: ready=%b ts=%h exp ts=%h", i, BRAM_ready_mask, bank_time_stamp, tsq[0]);
      end
      BRAM_rd_request = 1;
      tick;
      exp_w = fullq.pop_front();
      checks++;
      if (BRAM_rd_data !== exp_w) begin
        errors++; $display("FAIL rd_data word %0d: got %h exp %h", i, BRAM_rd_data, exp_w);
      end
      if (chk5 && i == 5) begin
        checks++;
        if (BRAM_rd_data[63:48] !== 16'h0503) begin
          errors++; $display("FAIL word5_lane3: got %h exp 0503", BRAM_rd_data[63:48]);
        end
      end
      last_w = exp_w;
    end
    void'(tsq.pop_front());
    full_banks--;
    checks++;
    if (BRAM_ready_mask !== 1'b0) begin
      errors++; $display("FAIL ready_after_release: got %b exp 0", BRAM_ready_mask);
    end
    tick;  // 129th request still asserted: must be ignored
    BRAM_rd_request = 0;
    checks++;
    if (BRAM_ready_mask !== 1'b0 || BRAM_rd_data !== last_w) begin
      errors++; $display("FAIL hold_cycle2: ready=%b data=%h exp ready 0 data %h", BRAM_ready_mask, BRAM_rd_data, last_w);
    end
    tick;
    checks++;
    if (BRAM_ready_mask !== (full_banks > 0)) begin
      errors++; $display("FAIL ready_after_hold: got %b exp %b", BRAM_ready_mask, full_banks > 0);
    end
  endtask

  task automatic test_reset;
    do_reset;
    rst_n = 1'b0; #1;
    checks++;
    if (BRAM_ready_mask !== 0 || BRAM_rd_data !== '0 || bank_time_stamp !== '0 || overflow !== 0 || pkt_err !== 0) begin
      errors++; $display("FAIL reset_outputs: ready=%b data=%h ts=%h ov=%b pe=%b exp all 0",
                         BRAM_ready_mask, BRAM_rd_data, bank_time_stamp, overflow, pkt_err);
    end
    do_reset;
  endtask

  task automatic test_fill_drain;
    do_reset;
    send_n(16, 16'h0100, 1, 0);
    checks++;
    if (BRAM_ready_mask !== 1'b0) begin
      errors++; $display("FAIL ready_early: got %b exp 0", BRAM_ready_mask);
    end
    tick;
    checks++;
    if (BRAM_ready_mask !== 1'b1 || bank_time_stamp !== 16'h0100) begin
      errors++; $display("FAIL ready_rise: ready=%b ts=%h exp 1 0100", BRAM_ready_mask, bank_time_stamp);
    end
    drain_bank(1);
  endtask

  task automatic test_back_to_back;
    do_reset;
    send_n(16, 16'h2000, 0, 1);
    send_n(16, 16'h3000, 0, 0);
    drain_bank(0);              // other bank FULL: ready returns right after the hold
    fork
      drain_bank(0);
      send_n(16, 16'h4000, 0, 1);
    join
    drain_bank(0);
  endtask

  task automatic test_overflow;
    do_reset;
    send_n(32, 16'h5000, 0, 0);
    send_pkt(16'h5555, 0, 128, 1);
`ifdef DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd1) begin
      errors++; $display("FAIL drop_count: got %0d exp 1", drop_count);
    end
`endif
    drain_bank(0);
    send_n(16, 16'h6000, 0, 0); // freed bank takes the next packets
    drain_bank(0);
    drain_bank(0);
  endtask

  task automatic test_pkt_err;
    do_reset;
    send_n(5, 16'h7000, 0, 0);
    send_pkt(16'h7005, 0, 60, 0);
    send_n(11, 16'h7100, 0, 1);
    drain_bank(0);
  endtask

  task automatic test_reset_mid;
    do_reset;
    send_n(16, 16'h8000, 0, 0);
    send_n(3, 16'h8100, 0, 0);
    send_pkt(16'h8200, 0, 40, 0);
    for (int i = 0; i < 10; i++) begin BRAM_rd_request = 1; tick; end
    #2 rst_n = 1'b0; BRAM_rd_request = 0;
    #1;
    checks++;
    if (BRAM_ready_mask !== 0 || BRAM_rd_data !== '0 || bank_time_stamp !== '0) begin
      errors++; $display("FAIL async_reset: ready=%b data=%h ts=%h exp all 0", BRAM_ready_mask, BRAM_rd_data, bank_time_stamp);
    end
    do_reset;
    send_n(16, 16'h0100, 1, 0);
    drain_bank(1);
  endtask

  initial begin
    model_reset;
    test_reset;
    test_fill_drain;
    test_back_to_back;
    test_overflow;
    test_pkt_err;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
